// File: rtl/decode_in_source.sv
// Transmit end of the LC3 decode_in bus: buffers host-loaded instructions in a
// FIFO and issues one per cycle with its PC+1, honouring stall and branch redirect.
module decode_in_source #(
  parameter int          DEPTH    = 8,
  parameter logic [15:0] PC_RESET = 16'h3000,
  localparam int         AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int         CW       = $clog2(DEPTH) + 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          load_valid,
  input  logic [15:0]   load_instr,
  output logic          load_ready,
  input  logic          stall,
  input  logic          br_taken,
  input  logic [15:0]   br_target,
  output logic [15:0]   instr_dout,
  output logic          enable_decode,
  output logic [15:0]   npc_in,
  output logic [15:0]   pc_out,
  output logic [CW-1:0] count,
  output logic [1:0]    state
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ISSUE = 2'd1,
    S_STALL = 2'd2
  } state_t;

  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  state_t        state_q;
  state_t        state_d;
  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [15:0]   pc;
  logic          wr_en;
  logic          rd_en;
  logic [CW-1:0] count_d;

  // Load handshake: a transfer happens on any edge where load_valid and
  // load_ready are both high; load_ready depends only on occupancy, never on
  // load_valid, so an issue on the same edge cannot open room for a write.
  assign load_ready = (count < FULL);
  assign wr_en      = load_valid && load_ready;
  assign rd_en      = (count != '0) && !stall;
  assign pc_out     = pc;
  assign state      = state_q;

  always_comb begin
    count_d = count;
    unique case ({wr_en, rd_en})
      2'b10:   count_d = count + CW'(1);
      2'b01:   count_d = count - CW'(1);
      default: count_d = count;
    endcase
  end

  // Storage carries no reset; resetting the pointers and count discards it.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_ptr] <= load_instr;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      pc            <= PC_RESET;
      instr_dout    <= 16'h0000;
      npc_in        <= 16'h0000;
      enable_decode <= 1'b0;
    end else begin
      count         <= count_d;
      enable_decode <= rd_en;
      if (wr_en) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (rd_en) begin
        instr_dout <= mem[rd_ptr];
        npc_in     <= pc + 16'd1;
        rd_ptr     <= rd_ptr + AW'(1);
      end
      // Redirect wins over the increment; an instruction issued on the same
      // edge still carries the pre-redirect pc + 1.
      if (br_taken) begin
        pc <= br_target;
      end else if (rd_en) begin
        pc <= pc + 16'd1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_EMPTY: begin
        if (wr_en) begin
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (stall) begin
          state_d = S_STALL;
        end else if (count_d == '0) begin
          state_d = S_EMPTY;
        end
      end
      S_STALL: begin
        if (!stall) begin
          state_d = (count_d != '0) ? S_ISSUE : S_EMPTY;
        end
      end
      default: state_d = S_EMPTY;
    endcase
  end

endmodule

// File: tb/tb_decode_in_source.sv
// Directed bench for decode_in_source: load, issue, full, stall, redirect,
// PC wrap and mid-stream reset, each checked against hand-computed values.
module tb_decode_in_source;

  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clock;
  logic          reset;
  logic          load_valid;
  logic [15:0]   load_instr;
  logic          load_ready;
  logic          stall;
  logic          br_taken;
  logic [15:0]   br_target;
  logic [15:0]   instr_dout;
  logic          enable_decode;
  logic [15:0]   npc_in;
  logic [15:0]   pc_out;
  logic [CW-1:0] count;
  logic [1:0]    state;

  int total;
  int bad;

  decode_in_source #(.DEPTH(DEPTH), .PC_RESET(16'h3000)) dut (
    .clock         (clock),
    .reset         (reset),
    .load_valid    (load_valid),
    .load_instr    (load_instr),
    .load_ready    (load_ready),
    .stall         (stall),
    .br_taken      (br_taken),
    .br_target     (br_target),
    .instr_dout    (instr_dout),
    .enable_decode (enable_decode),
    .npc_in        (npc_in),
    .pc_out        (pc_out),
    .count         (count),
    .state         (state)
  );

  // Clock / reset block
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // Driver tasks
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_issue(input string tag, input logic [15:0] ins, input logic [15:0] npc);
    check({tag, "_en"}, 32'(enable_decode), 32'd1);
    check({tag, "_instr"}, 32'(instr_dout), 32'(ins));
    check({tag, "_npc"}, 32'(npc_in), 32'(npc));
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    reset      = 1'b1;
    load_valid = 1'b0;
    load_instr = 16'h0000;
    stall      = 1'b0;
    br_taken   = 1'b0;
    br_target  = 16'h0000;
    tick();
    tick();

    // Reset state
    check("rst_ready", 32'(load_ready), 32'd1);
    check("rst_en", 32'(enable_decode), 32'd0);
    check("rst_pc", 32'(pc_out), 32'h3000);
    check("rst_count", 32'(count), 32'd0);
    check("rst_instr", 32'(instr_dout), 32'h0);
    check("rst_npc", 32'(npc_in), 32'h0);
    check("rst_state", 32'(state), 32'd0);
    reset = 1'b0;

    // Back-to-back writes, issue one cycle after each write
    load_valid = 1'b1;
    load_instr = 16'h1234;
    tick();
    check("t1_w0_count", 32'(count), 32'd1);
    check("t1_w0_en", 32'(enable_decode), 32'd0);
    load_instr = 16'h5678;
    tick();
    check_issue("t1_i0", 16'h1234, 16'h3001);
    check("t1_i0_count", 32'(count), 32'd1);
    load_valid = 1'b0;
    tick();
    check_issue("t1_i1", 16'h5678, 16'h3002);
    check("t1_pc", 32'(pc_out), 32'h3002);
    check("t1_count", 32'(count), 32'd0);
    tick();
    check("t1_idle_en", 32'(enable_decode), 32'd0);
    check("t1_idle_instr", 32'(instr_dout), 32'h5678);
    check("t1_idle_state", 32'(state), 32'd0);

    // Fill under stall, overflow write dropped
    stall      = 1'b1;
    load_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      load_instr = 16'hA000 + 16'(i);
      tick();
    end
    check("t2_full_count", 32'(count), 32'd8);
    check("t2_full_ready", 32'(load_ready), 32'd0);
    check("t2_full_state", 32'(state), 32'd2);
    check("t2_full_en", 32'(enable_decode), 32'd0);
    load_instr = 16'hBEEF;
    tick();
    check("t2_drop_count", 32'(count), 32'd8);
    stall = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      load_valid = 1'b0;
      if (i == 0) check("t2_full_issue_count", 32'(count), 32'd7);
      check_issue("t2_drain", 16'hA000 + 16'(i), 16'h3003 + 16'(i));
    end
    check("t2_drain_count", 32'(count), 32'd0);
    check("t2_drain_state", 32'(state), 32'd0);
    check("t2_drain_pc", 32'(pc_out), 32'h300A);
    tick();
    check("t2_noextra_en", 32'(enable_decode), 32'd0);
    check("t2_noextra_instr", 32'(instr_dout), 32'hA007);

    // Three-cycle stall in the middle of a stream
    stall      = 1'b1;
    load_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      load_instr = 16'hC000 + 16'(i);
      tick();
    end
    load_valid = 1'b0;
    stall      = 1'b0;
    tick();
    check_issue("t3_i0", 16'hC000, 16'h300B);
    tick();
    check_issue("t3_i1", 16'hC001, 16'h300C);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t3_stall_en", 32'(enable_decode), 32'd0);
      check("t3_stall_instr", 32'(instr_dout), 32'hC001);
      check("t3_stall_npc", 32'(npc_in), 32'h300C);
    end
    check("t3_stall_state", 32'(state), 32'd2);
    stall = 1'b0;
    tick();
    check_issue("t3_i2", 16'hC002, 16'h300D);
    tick();
    check_issue("t3_i3", 16'hC003, 16'h300E);
    check("t3_count", 32'(count), 32'd0);

    // Redirect on an issue edge
    br_taken  = 1'b1;
    br_target = 16'h3005;
    tick();
    br_taken = 1'b0;
    check("t4_setpc", 32'(pc_out), 32'h3005);
    check("t4_setpc_en", 32'(enable_decode), 32'd0);
    stall      = 1'b1;
    load_valid = 1'b1;
    load_instr = 16'hD000;
    tick();
    load_instr = 16'hD001;
    tick();
    load_valid = 1'b0;
    stall      = 1'b0;
    br_taken   = 1'b1;
    br_target  = 16'h4000;
    tick();
    br_taken = 1'b0;
    check_issue("t4_br_issue", 16'hD000, 16'h3006);
    check("t4_br_pc", 32'(pc_out), 32'h4000);
    tick();
    check_issue("t4_after_br", 16'hD001, 16'h4001);

    // Redirect to the top of the address space, PC wraps
    br_taken  = 1'b1;
    br_target = 16'hFFFF;
    tick();
    br_taken = 1'b0;
    check("t5_pc", 32'(pc_out), 32'hFFFF);
    stall      = 1'b1;
    load_valid = 1'b1;
    load_instr = 16'hE000;
    tick();
    load_instr = 16'hE001;
    tick();
    load_valid = 1'b0;
    stall      = 1'b0;
    tick();
    check_issue("t5_wrap0", 16'hE000, 16'h0000);
    tick();
    check_issue("t5_wrap1", 16'hE001, 16'h0001);
    check("t5_pc_end", 32'(pc_out), 32'h0001);

    // Reset with five entries queued
    stall      = 1'b1;
    load_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      load_instr = 16'hF000 + 16'(i);
      tick();
    end
    load_valid = 1'b0;
    check("t6_queued", 32'(count), 32'd5);
    stall = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t6_rst_en", 32'(enable_decode), 32'd0);
    check("t6_rst_count", 32'(count), 32'd0);
    check("t6_rst_pc", 32'(pc_out), 32'h3000);
    check("t6_rst_state", 32'(state), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t6_no_stale", 32'(enable_decode), 32'd0);
    end
    load_valid = 1'b1;
    load_instr = 16'h9999;
    tick();
    load_valid = 1'b0;
    tick();
    check_issue("t6_fresh", 16'h9999, 16'h3001);
    tick();
    check("t6_fresh_end", 32'(enable_decode), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
